// File: rtl/fir_pkg.sv
// Definitions shared across the FIR filter: the sample width and type, and how
// wide a FIFO occupancy counter has to be.
package fir_pkg;

   localparam int unsigned FIR_DATA_WIDTH = 24;

   typedef logic signed [FIR_DATA_WIDTH-1:0] fir_sample_t;

   // Occupancy needs one bit more than a pointer so that "full" can be represented.
   function automatic int unsigned fir_level_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO for the FIR output stage. Occupancy is held in an explicit
// counter, so full and empty are never ambiguous. An empty FIFO never bypasses.
module fir_sync_fifo
   import fir_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
   parameter int unsigned DEPTH      = 8
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_wr,
   input  logic [DATA_WIDTH-1:0]             iv_wdata,
   input  logic                              i_rd,
   output logic [DATA_WIDTH-1:0]             ov_rdata_c,
   output logic                              o_wr_ok_c,
   output logic [fir_level_width(DEPTH)-1:0] ov_level
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = fir_level_width(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic                  full_c;
   logic                  empty_c;
   logic                  rd_ok_c;

   // When the FIFO is full, a write is still accepted if a read frees the head slot in the same cycle.
   always_comb begin
      full_c     = (ov_level == LW'(DEPTH));
      empty_c    = (ov_level == '0);
      rd_ok_c    = i_rd & ~empty_c;
      o_wr_ok_c  = i_wr & (~full_c | rd_ok_c);
      ov_rdata_c = empty_c ? '0 : mem[rd_ptr];
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         ov_level <= '0;
      end else begin
         if (o_wr_ok_c) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok_c)   rd_ptr <= rd_ptr + AW'(1);
         case ({o_wr_ok_c, rd_ok_c})
            2'b10:   ov_level <= ov_level + LW'(1);
            2'b01:   ov_level <= ov_level - LW'(1);
            default: ov_level <= ov_level;
         endcase
      end
   end

   // Storage has no reset; the occupancy counter decides what is valid.
   always_ff @(posedge i_clk) begin
      if (o_wr_ok_c) mem[wr_ptr] <= iv_wdata;
   end

endmodule

// File: rtl/fir_out_buffer.sv
// FIR output stage: captures the last tap's sum through an enable pipeline and queues it for a valid/ready sink.
// Peak-magnitude tracking is built only when FIR_OUT_PEAK_EN is defined.
module fir_out_buffer
   import fir_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FIR_DATA_WIDTH,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned SUM_LAT    = 1
) (
   input  logic                              i_clk,
   input  logic                              i_rst,
   input  logic                              i_en,
   input  logic [DATA_WIDTH-1:0]             iv_sum,
   output logic [DATA_WIDTH-1:0]             ov_tdata,
   output logic                              o_tvalid,
   input  logic                              i_tready,
   output logic [fir_level_width(DEPTH)-1:0] ov_level,
   output logic                              o_overflow,
   input  logic                              i_clr_stat,
   output logic [DATA_WIDTH-2:0]             ov_peak
);

   logic [SUM_LAT-1:0] en_pipe;
   logic               wr_req;
   logic               wr_ok_c;
   logic               rd_c;

   // Delays the sample-step enable until the tap sum it refers to is valid.
   generate
      if (SUM_LAT > 1) begin : g_pipe_multi
         always_ff @(posedge i_clk) begin
            if (i_rst) en_pipe <= '0;
            else       en_pipe <= {en_pipe[SUM_LAT-2:0], i_en};
         end
      end else begin : g_pipe_single
         always_ff @(posedge i_clk) begin
            if (i_rst) en_pipe <= '0;
            else       en_pipe <= i_en;
         end
      end
   endgenerate

   assign wr_req   = en_pipe[SUM_LAT-1];
   assign o_tvalid = (ov_level != '0);
   assign rd_c     = o_tvalid & i_tready;

   fir_sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_fifo (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_wr       (wr_req),
      .iv_wdata   (iv_sum),
      .i_rd       (rd_c),
      .ov_rdata_c (ov_tdata),
      .o_wr_ok_c  (wr_ok_c),
      .ov_level   (ov_level)
   );

   // Sticky drop flag; if a drop and a clear arrive in the same cycle, the drop wins.
   always_ff @(posedge i_clk) begin
      if (i_rst)                   o_overflow <= 1'b0;
      else if (wr_req & ~wr_ok_c)  o_overflow <= 1'b1;
      else if (i_clr_stat)         o_overflow <= 1'b0;
   end

`ifdef FIR_OUT_PEAK_EN
   logic [DATA_WIDTH-1:0] neg_c;
   logic [DATA_WIDTH-2:0] abs_c;

   // |sample|, with the most negative code saturating to the largest positive magnitude.
   always_comb begin
      neg_c = ~iv_sum + DATA_WIDTH'(1);
      abs_c = iv_sum[DATA_WIDTH-2:0];
      if (iv_sum[DATA_WIDTH-1]) begin
         if (iv_sum[DATA_WIDTH-2:0] == '0) abs_c = '1;
         else                              abs_c = neg_c[DATA_WIDTH-2:0];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ov_peak <= '0;
      end else if (wr_ok_c) begin
         if (i_clr_stat || (abs_c > ov_peak)) ov_peak <= abs_c;
      end else if (i_clr_stat) begin
         ov_peak <= '0;
      end
   end
`else
   assign ov_peak = '0;
`endif

endmodule
